// File: rtl/isa_pkg.sv
// ISA constants shared by the miniGame program loader: opcodes, field positions,
// instruction format and loader FSM state types.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int unsigned FIELD_W   = 5;
  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_LSB = 2;
  localparam int unsigned IMM_W     = 17;
  localparam int unsigned TGT_W     = 27;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Unknown opcodes fall into JI so an unchecked build still packs something sensible.
  function automatic fmt_e fmt_of(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:                            f = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: f = FMT_I;
      OP_JR:                               f = FMT_JII;
      default:                             f = FMT_JI;
    endcase
    return f;
  endfunction

  function automatic logic op_known(input logic [4:0] op);
    logic k;
    case (op)
      OP_RTYPE, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI,
      OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX: k = 1'b1;
      default:                               k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational encoder: request fields -> 32-bit ISA word plus legality flag.
// Opcode/immediate legality checks exist only when INSN_LOADER_CHECK_EN is defined.
module insn_pack
  import isa_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_shamt,
  input  logic [4:0]  i_aluop,
  input  logic [31:0] i_imm,
  input  logic [26:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  fmt_e w_fmt;

  assign w_fmt = fmt_of(i_opcode);

  always_comb begin
    o_word = '0;
    o_word[OP_LSB +: FIELD_W] = i_opcode;
    case (w_fmt)
      FMT_R: begin
        o_word[RD_LSB    +: FIELD_W] = i_rd;
        o_word[RS_LSB    +: FIELD_W] = i_rs;
        o_word[RT_LSB    +: FIELD_W] = i_rt;
        o_word[SHAMT_LSB +: FIELD_W] = i_shamt;
        o_word[ALUOP_LSB +: FIELD_W] = i_aluop;
      end
      FMT_I: begin
        o_word[RD_LSB +: FIELD_W] = i_rd;
        o_word[RS_LSB +: FIELD_W] = i_rs;
        o_word[0 +: IMM_W]        = i_imm[IMM_W-1:0];
      end
      FMT_JII: begin
        o_word[RD_LSB +: FIELD_W] = i_rd;
      end
      FMT_JI: begin
        o_word[0 +: TGT_W] = i_target;
      end
    endcase
  end

`ifdef INSN_LOADER_CHECK_EN
  logic w_known;
  logic w_imm_ok;

  assign w_known  = op_known(i_opcode);
  // A 17-bit signed value sign-extends into bits [31:16] unchanged.
  assign w_imm_ok = (i_imm[31:16] == '0) || (i_imm[31:16] == '1);
  assign o_legal  = w_known && ((w_fmt != FMT_I) || w_imm_ok);
`else
  logic w_unused_imm;

  assign w_unused_imm = ^i_imm[31:IMM_W];
  assign o_legal      = 1'b1;
`endif

endmodule

// File: rtl/insn_loader.sv
// Streams field-level instruction requests into IMEM as packed 32-bit words.
// Build with INSN_LOADER_CHECK_EN to reject undefined opcodes and out-of-range immediates.
module insn_loader
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_opcode,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_shamt,
  input  logic [4:0]        req_aluop,
  input  logic [31:0]       req_imm,
  input  logic [26:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  state_e            r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_count;
  logic              r_last;
  logic              r_full;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_hs;
  logic              w_at_top;

  insn_pack u_pack (
    .i_opcode (req_opcode),
    .i_rd     (req_rd),
    .i_rs     (req_rs),
    .i_rt     (req_rt),
    .i_shamt  (req_shamt),
    .i_aluop  (req_aluop),
    .i_imm    (req_imm),
    .i_target (req_target),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign w_hs     = req_valid & r_ready;
  assign w_at_top = (r_addr == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= ADDR_BASE;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_full  <= 1'b0;
    end else if (start) begin
      // A pending write strobe has already been presented this cycle; only the
      // pointer bookkeeping is discarded.
      r_state <= ST_LOAD;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= ADDR_BASE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
        end
        ST_LOAD: begin
          if (w_hs) begin
            if (w_legal && !r_full) begin
              r_wdata <= w_word;
              r_last  <= req_last;
              r_we    <= 1'b1;
              r_ready <= 1'b0;
              r_state <= ST_WRITE;
            end else begin
              r_err <= 1'b1;
              if (req_last) begin
                r_ready <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
        end
        ST_WRITE: begin
          r_count <= r_count + CNT_ONE;
          if (w_at_top) begin
            r_full <= 1'b1;
          end else begin
            r_addr <= r_addr + ADDR_ONE;
          end
          if (r_last) begin
            r_ready <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign err        = r_err;
  assign count      = r_count;

endmodule
